// File: rtl/uart_alu_ctrl.sv
// UART command front-end for an ALU: collects opcode/A/B frames, launches the ALU, returns the 16-bit result as two bytes.
// Optional inter-byte timeout in GET_A/GET_B is enabled by defining UART_ALU_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
   parameter int         TIMEOUT_CYCLES = 54300,
   parameter logic [7:0] MAX_OPCODE     = 8'h07
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic [7:0]  alu_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic        alu_start,
   input  logic        alu_done,
   input  logic [15:0] alu_result,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   input  logic        tx_busy,
   output logic        busy,
   output logic        frame_err,
   output logic        rx_overrun
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      GET_A      = 4'd1,
      GET_B      = 4'd2,
      EXEC       = 4'd3,
      WAIT_ALU   = 4'd4,
      TX_HI      = 4'd5,
      TX_HI_WAIT = 4'd6,
      TX_LO      = 4'd7,
      TX_LO_WAIT = 4'd8,
      ERR_TX     = 4'd9
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  alu_op_q, alu_op_d;
   logic [7:0]  alu_a_q, alu_a_d;
   logic [7:0]  alu_b_q, alu_b_d;
   logic        alu_start_q, alu_start_d;
   logic [15:0] result_q, result_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        tx_start_q, tx_start_d;
   logic        busy_q, busy_d;
   logic        frame_err_q, frame_err_d;
   logic        rx_overrun_q, rx_overrun_d;
   // ERR_TX has two phases: waiting to launch 8'hEE, then waiting for the transmitter to drain.
   logic        err_sent_q, err_sent_d;

   if (TIMEOUT_CYCLES < 1) begin : g_cfg_chk
      $error("uart_alu_ctrl: TIMEOUT_CYCLES must be at least 1");
   end

`ifdef UART_ALU_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] TO_ONE   = CNT_W'(1);
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

   // Next-state and next-output logic for the frame sequencer.
   always_comb begin
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      result_d     = result_q;
      tx_data_d    = tx_data_q;
      err_sent_d   = err_sent_q;
      alu_start_d  = 1'b0;
      tx_start_d   = 1'b0;
      frame_err_d  = 1'b0;
      rx_overrun_d = rx_valid && !(state_q inside {IDLE, GET_A, GET_B});
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      to_cnt_d     = '0;
`endif
      case (state_q)
         IDLE: begin
            if (rx_valid) begin
               alu_op_d = rx_data;
               if (rx_data <= MAX_OPCODE) begin
                  state_d = GET_A;
               end else begin
                  frame_err_d = 1'b1;
                  err_sent_d  = 1'b0;
                  state_d     = ERR_TX;
               end
            end else begin
               state_d = IDLE;
            end
         end
         GET_A: begin
            if (rx_valid) begin
               alu_a_d = rx_data;
               state_d = GET_B;
            end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            else if (to_cnt_q == TO_LIMIT) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
`else
            else begin
               state_d = GET_A;
            end
`endif
         end
         GET_B: begin
            if (rx_valid) begin
               alu_b_d     = rx_data;
               alu_start_d = 1'b1;
               state_d     = EXEC;
            end
`ifdef UART_ALU_CTRL_TIMEOUT_EN
            else if (to_cnt_q == TO_LIMIT) begin
               frame_err_d = 1'b1;
               state_d     = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
`else
            else begin
               state_d = GET_B;
            end
`endif
         end
         // alu_start is high throughout EXEC, so an alu_done here is never taken as the answer.
         EXEC: begin
            state_d = WAIT_ALU;
         end
         WAIT_ALU: begin
            if (alu_done) begin
               result_d = alu_result;
               state_d  = TX_HI;
            end else begin
               state_d = WAIT_ALU;
            end
         end
         TX_HI: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = result_q[15:8];
               state_d    = TX_HI_WAIT;
            end else begin
               state_d = TX_HI;
            end
         end
         TX_HI_WAIT: begin
            if (!tx_start_q && !tx_busy) begin
               state_d = TX_LO;
            end else begin
               state_d = TX_HI_WAIT;
            end
         end
         TX_LO: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = result_q[7:0];
               state_d    = TX_LO_WAIT;
            end else begin
               state_d = TX_LO;
            end
         end
         TX_LO_WAIT: begin
            if (!tx_start_q && !tx_busy) begin
               state_d = IDLE;
            end else begin
               state_d = TX_LO_WAIT;
            end
         end
         ERR_TX: begin
            if (!err_sent_q) begin
               if (!tx_busy) begin
                  tx_start_d = 1'b1;
                  tx_data_d  = 8'hEE;
                  err_sent_d = 1'b1;
               end else begin
                  err_sent_d = 1'b0;
               end
            end else if (!tx_start_q && !tx_busy) begin
               err_sent_d = 1'b0;
               state_d    = IDLE;
            end else begin
               state_d = ERR_TX;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         alu_op_q     <= 8'h00;
         alu_a_q      <= 8'h00;
         alu_b_q      <= 8'h00;
         alu_start_q  <= 1'b0;
         result_q     <= 16'h0000;
         tx_data_q    <= 8'h00;
         tx_start_q   <= 1'b0;
         busy_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_overrun_q <= 1'b0;
         err_sent_q   <= 1'b0;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_start_q  <= alu_start_d;
         result_q     <= result_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         busy_q       <= busy_d;
         frame_err_q  <= frame_err_d;
         rx_overrun_q <= rx_overrun_d;
         err_sent_q   <= err_sent_d;
`ifdef UART_ALU_CTRL_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
`endif
      end
   end

   assign alu_op     = alu_op_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_start  = alu_start_q;
   assign tx_data    = tx_data_q;
   assign tx_start   = tx_start_q;
   assign busy       = busy_q;
   assign frame_err  = frame_err_q;
   assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: frame-level scoreboard (expected launches, tx bytes, error/overrun pulses) checked every cycle.
// Honours UART_ALU_CTRL_TIMEOUT_EN for the silence-after-opcode case.
module tb_uart_alu_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  alu_op, alu_a, alu_b;
   logic        alu_start;
   logic        alu_done;
   logic [15:0] alu_result;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_busy;
   logic        tx_model, tx_force;
   logic        busy, frame_err, rx_overrun;

   assign tx_busy = tx_model | tx_force;

   uart_alu_ctrl #(.TIMEOUT_CYCLES(100), .MAX_OPCODE(8'h07)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
      .alu_done(alu_done), .alu_result(alu_result),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .busy(busy), .frame_err(frame_err), .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [23:0] exp_launch[$];
   logic [7:0]  exp_tx[$];
   logic [7:0]  tx_log[$];
   int          exp_ferr = 0;
   int          exp_ovr  = 0;
   int          tx_len    = 4;
   int          alu_delay = 2;
   bit          alu_early = 1'b0;
   bit          held_valid = 1'b0;
   logic [23:0] held;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [15:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         8'h00, 8'h01: return {8'h00, a} + {8'h00, b};
         8'h02:        return {8'h00, a} * {8'h00, b};
         default:      return {8'h00, a ^ b};
      endcase
   endfunction

   // ALU stand-in: optional bogus done in the launch cycle, then the real result after alu_delay cycles.
   initial begin
      logic [7:0] op, a, b;
      alu_done = 1'b0;
      alu_result = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (alu_start && !rst) begin
            op = alu_op; a = alu_a; b = alu_b;
            if (alu_early) begin
               alu_done = 1'b1;
               alu_result = 16'hDEAD;
            end
            @(posedge clk); #1;
            alu_done = 1'b0;
            repeat (alu_delay) @(posedge clk);
            #1;
            alu_done = 1'b1;
            alu_result = alu_fn(op, a, b);
            @(posedge clk); #1;
            alu_done = 1'b0;
            alu_result = 16'h0000;
         end
      end
   end

   // Transmitter stand-in: busy rises the cycle after tx_start and lasts tx_len cycles.
   initial begin
      tx_model = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (tx_start && !rst) begin
            @(posedge clk); #1;
            tx_model = 1'b1;
            repeat (tx_len) @(posedge clk);
            #1;
            tx_model = 1'b0;
         end
      end
   end

   // Compare process: every pulse must match a pending expectation; operands held while busy.
   always @(negedge clk) begin
      if (rst) begin
         held_valid = 1'b0;
      end else begin
         if (alu_start) begin
            if (exp_launch.size() == 0) begin
               chk("alu_start_extra", {31'd0, alu_start}, 32'd0);
            end else begin
               held = exp_launch.pop_front();
               chk("alu_launch", {8'h00, alu_op, alu_a, alu_b}, {8'h00, held});
               held_valid = 1'b1;
            end
         end else if (held_valid && busy) begin
            chk("alu_hold", {8'h00, alu_op, alu_a, alu_b}, {8'h00, held});
         end
         if (!busy) held_valid = 1'b0;
         if (tx_start) begin
            tx_log.push_back(tx_data);
            chk("tx_start_busy", {31'd0, tx_busy}, 32'd0);
            if (exp_tx.size() == 0) chk("tx_start_extra", {31'd0, tx_start}, 32'd0);
            else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
         end
         if (frame_err) begin
            chk("frame_err_pending", (exp_ferr > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_ferr > 0) exp_ferr--;
         end
         if (rx_overrun) begin
            chk("rx_overrun_pending", (exp_ovr > 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_ovr > 0) exp_ovr--;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] r;
      if (op <= 8'h07) begin
         r = alu_fn(op, a, b);
         exp_launch.push_back({op, a, b});
         exp_tx.push_back(r[15:8]);
         exp_tx.push_back(r[7:0]);
         send_byte(op);
         send_byte(a);
         send_byte(b);
      end else begin
         exp_ferr++;
         exp_tx.push_back(8'hEE);
         send_byte(op);
      end
   endtask

   task automatic wait_idle(input string name, output int n);
      n = 0;
      while (busy && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      chk(name, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int n;
      rst = 1'b1;
      rx_data = 8'h00;
      rx_valid = 1'b0;
      tx_force = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_outputs", {alu_op, alu_a, alu_b, tx_data}, 32'd0);
      chk("rst_pulses", {27'd0, alu_start, tx_start, busy, frame_err, rx_overrun}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // 01,05,03 with a bogus same-cycle alu_done that must be ignored
      tx_log.delete();
      alu_early = 1'b1;
      send_frame(8'h01, 8'h05, 8'h03);
      wait_idle("t1_idle", n);
      alu_early = 1'b0;
      chk("t1_nbytes", tx_log.size(), 32'd2);
      chk("t1_hi", {24'd0, tx_log[0]}, 32'h00);
      chk("t1_lo", {24'd0, tx_log[1]}, 32'h08);

      // bad opcode, then an immediate valid frame
      tx_log.delete();
      send_frame(8'h20, 8'h00, 8'h00);
      wait_idle("t2_err_idle", n);
      send_frame(8'h00, 8'h02, 8'h02);
      wait_idle("t2_idle", n);
      chk("t2_nbytes", tx_log.size(), 32'd3);
      chk("t2_err_byte", {24'd0, tx_log[0]}, 32'hEE);
      chk("t2_lo", {24'd0, tx_log[2]}, 32'h04);

      // transmitter held busy for 1000 cycles while TX_HI is pending
      tx_log.delete();
      tx_force = 1'b1;
      send_frame(8'h02, 8'hFF, 8'hFF);
      repeat (1000) @(posedge clk);
      #1;
      chk("t3_no_tx", tx_log.size(), 32'd0);
      chk("t3_busy", {31'd0, busy}, 32'd1);
      tx_force = 1'b0;
      wait_idle("t3_idle", n);
      chk("t3_nbytes", tx_log.size(), 32'd2);
      chk("t3_hi", {24'd0, tx_log[0]}, 32'hFE);
      chk("t3_lo", {24'd0, tx_log[1]}, 32'h01);

      // byte 55 arriving during WAIT_ALU is dropped
      tx_log.delete();
      alu_delay = 20;
      send_frame(8'h03, 8'h12, 8'h34);
      repeat (3) @(posedge clk);
      #1;
      exp_ovr++;
      send_byte(8'h55);
      wait_idle("t4_idle", n);
      alu_delay = 2;
      chk("t4_a", {24'd0, alu_a}, 32'h12);
      chk("t4_b", {24'd0, alu_b}, 32'h34);
      chk("t4_lo", {24'd0, tx_log[1]}, 32'h26);

      // opcode followed by silence
`ifdef UART_ALU_CTRL_TIMEOUT_EN
      tx_log.delete();
      exp_ferr++;
      send_byte(8'h05);
      wait_idle("t5_timeout_idle", n);
      chk("t5_timeout_cycles", n, 32'd101);
      chk("t5_no_tx", tx_log.size(), 32'd0);
`else
      tx_log.delete();
      send_byte(8'h05);
      repeat (200) @(posedge clk);
      #1;
      chk("t5_still_busy", {31'd0, busy}, 32'd1);
      exp_launch.push_back({8'h05, 8'h01, 8'h02});
      exp_tx.push_back(8'h00);
      exp_tx.push_back(8'h03);
      send_byte(8'h01);
      send_byte(8'h02);
      wait_idle("t5_idle", n);
      chk("t5_lo", {24'd0, tx_log[1]}, 32'h03);
`endif

      // reset while in TX_LO_WAIT, then a fresh frame
      tx_log.delete();
      tx_len = 10;
      send_frame(8'h01, 8'h10, 8'h20);
      n = 0;
      while (tx_log.size() < 2 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("t6_reached_lo", tx_log.size(), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_rst_outputs", {alu_op, alu_a, alu_b, tx_data}, 32'd0);
      chk("t6_rst_pulses", {27'd0, alu_start, tx_start, busy, frame_err, rx_overrun}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      tx_len = 4;
      tx_log.delete();
      send_frame(8'h00, 8'h07, 8'h08);
      wait_idle("t6_idle", n);
      chk("t6_hi", {24'd0, tx_log[0]}, 32'h00);
      chk("t6_lo", {24'd0, tx_log[1]}, 32'h0F);

      repeat (5) @(posedge clk);
      #1;
      chk("left_launch", exp_launch.size(), 32'd0);
      chk("left_tx", exp_tx.size(), 32'd0);
      chk("left_ferr", exp_ferr, 32'd0);
      chk("left_ovr", exp_ovr, 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
